// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single fixed-latency memory, one access at a time.
// Define ARB_FIXED_PRIO_EN to make port 0 win every tie instead of round-robin.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic          gclk,
    input  logic          rst,
    input  logic          rd0,
    input  logic          rd1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic [DW-1:0] mem_data,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rd,
    output logic          mem_we,
    output logic          valid0,
    output logic          valid1,
    output logic [DW-1:0] data0,
    output logic [DW-1:0] data1,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          grant_q, grant_d;
    logic          is_wr_q, is_wr_d;
    logic          last_grant_q, last_grant_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_rd_q, mem_rd_d;
    logic          mem_we_q, mem_we_d;
    logic          valid0_q, valid0_d;
    logic          valid1_q, valid1_d;
    logic [DW-1:0] data0_q, data0_d;
    logic [DW-1:0] data1_q, data1_d;
    logic          busy_q, busy_d;

    logic          req0, req1;
    logic          win1;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    assign req0 = rd0 | we0;
    assign req1 = rd1 | we1;

`ifdef ARB_FIXED_PRIO_EN
    assign win1 = req1 & ~req0;
`else
    // On a tie the port that did not win last time goes next.
    assign win1 = req1 & (~req0 | ~last_grant_q);
`endif

    assign win_we    = win1 ? we1    : we0;
    assign win_addr  = win1 ? addr1  : addr0;
    assign win_wdata = win1 ? wdata1 : wdata0;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        is_wr_d      = is_wr_q;
        last_grant_d = last_grant_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_rd_d     = 1'b0;
        mem_we_d     = 1'b0;
        valid0_d     = 1'b0;
        valid1_d     = 1'b0;
        data0_d      = data0_q;
        data1_d      = data1_q;
        busy_d       = busy_q;

        unique case (state_q)
            S_IDLE: begin
                if (req0 | req1) begin
                    state_d      = S_ISSUE;
                    grant_d      = win1;
                    last_grant_d = win1;
                    is_wr_d      = win_we;
                    mem_addr_d   = win_addr;
                    mem_rd_d     = ~win_we;
                    mem_we_d     = win_we;
                    busy_d       = 1'b1;
                    if (win_we) begin
                        mem_wdata_d = win_wdata;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d = '0;
                if (is_wr_q) begin
                    state_d  = S_DONE;
                    valid0_d = ~grant_q;
                    valid1_d = grant_q;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == LAST_CNT) begin
                    state_d  = S_DONE;
                    valid0_d = ~grant_q;
                    valid1_d = grant_q;
                    if (grant_q) begin
                        data1_d = mem_data;
                    end else begin
                        data0_d = mem_data;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge gclk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            grant_q      <= 1'b0;
            is_wr_q      <= 1'b0;
            last_grant_q <= 1'b1;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_rd_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            valid0_q     <= 1'b0;
            valid1_q     <= 1'b0;
            data0_q      <= '0;
            data1_q      <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            is_wr_q      <= is_wr_d;
            last_grant_q <= last_grant_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_rd_q     <= mem_rd_d;
            mem_we_q     <= mem_we_d;
            valid0_q     <= valid0_d;
            valid1_q     <= valid1_d;
            data0_q      <= data0_d;
            data1_q      <= data1_d;
            busy_q       <= busy_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_rd    = mem_rd_q;
    assign mem_we    = mem_we_q;
    assign valid0    = valid0_q;
    assign valid1    = valid1_q;
    assign data0     = data0_q;
    assign data1     = data1_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reads, writes, ties, rd+we overlap, reset mid-read.
// Builds with or without ARB_FIXED_PRIO_EN; tie expectations follow the macro.
module tb_mem_arbiter;

    logic        gclk;
    logic        rst;
    logic        rd0, rd1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [31:0] mem_data;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_rd, mem_we;
    logic        valid0, valid1;
    logic [31:0] data0, data1;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(2)) dut (
        .gclk      (gclk),
        .rst       (rst),
        .rd0       (rd0),
        .rd1       (rd1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .mem_data  (mem_data),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd),
        .mem_we    (mem_we),
        .valid0    (valid0),
        .valid1    (valid1),
        .data0     (data0),
        .data1     (data1),
        .busy      (busy)
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge gclk);
        #1;
    endtask

    // Strobes and valids must be mutually exclusive every cycle.
    always @(negedge gclk) begin
        check("excl", {30'd0, mem_rd & mem_we, valid0 & valid1}, 32'd0);
    end

    int exp_port[3];
    int n;

    initial begin
`ifdef ARB_FIXED_PRIO_EN
        exp_port = '{0, 0, 0};
`else
        exp_port = '{0, 1, 0};
`endif
        rst = 1'b1;
        rd0 = 0; rd1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        mem_data = '0;
        tick;
        tick;
        check("rst_addr", mem_addr, 32'd0);
        check("rst_rd", {31'd0, mem_rd}, 32'd0);
        check("rst_v0", {31'd0, valid0}, 32'd0);
        check("rst_d0", data0, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        tick;

        // Single read on port 0; data only valid in the last WAIT cycle.
        addr0 = 32'hFFFF_FFFF; rd0 = 1; mem_data = 32'h5555_5555;
        tick;
        check("rd_strobe", {31'd0, mem_rd}, 32'd1);
        check("rd_we", {31'd0, mem_we}, 32'd0);
        check("rd_addr", mem_addr, 32'hFFFF_FFFF);
        check("rd_busy", {31'd0, busy}, 32'd1);
        tick;
        check("rd_strobe1", {31'd0, mem_rd}, 32'd0);
        tick;
        check("rd_early_v", {31'd0, valid0}, 32'd0);
        mem_data = 32'hAAAA_AAAA;
        tick;
        check("rd_v0", {31'd0, valid0}, 32'd1);
        check("rd_v1", {31'd0, valid1}, 32'd0);
        check("rd_d0", data0, 32'hAAAA_AAAA);
        check("rd_d1", data1, 32'd0);
        rd0 = 0; mem_data = 32'h5555_5555;
        tick;
        check("rd_v0_end", {31'd0, valid0}, 32'd0);
        check("rd_idle", {31'd0, busy}, 32'd0);

        // Single write on port 1.
        addr1 = 32'h10; wdata1 = 32'h1234_5678; we1 = 1;
        tick;
        check("wr_strobe", {31'd0, mem_we}, 32'd1);
        check("wr_rd", {31'd0, mem_rd}, 32'd0);
        check("wr_addr", mem_addr, 32'h10);
        check("wr_wdata", mem_wdata, 32'h1234_5678);
        tick;
        check("wr_v1", {31'd0, valid1}, 32'd1);
        check("wr_d1", data1, 32'd0);
        we1 = 0;
        tick;
        check("wr_v1_end", {31'd0, valid1}, 32'd0);
        check("wr_hold_addr", mem_addr, 32'h10);

        // Both ports read continuously.
        addr0 = 32'h100; addr1 = 32'h200; rd0 = 1; rd1 = 1;
        for (int g = 0; g < 3; g++) begin
            mem_data = 32'hC0DE_0000 + g;
            n = 1;
            tick;
            while (!mem_rd && n < 10) begin
                tick;
                n++;
            end
            check("tie_gap", n, (g == 0) ? 32'd1 : 32'd2);
            check("tie_addr", mem_addr,
                  (exp_port[g] == 1) ? 32'h200 : 32'h100);
            tick;
            tick;
            tick;
            check("tie_v0", {31'd0, valid0}, (exp_port[g] == 0) ? 32'd1 : 32'd0);
            check("tie_v1", {31'd0, valid1}, (exp_port[g] == 1) ? 32'd1 : 32'd0);
            check("tie_data", (exp_port[g] == 1) ? data1 : data0,
                  32'hC0DE_0000 + g);
        end
        rd0 = 0; rd1 = 0;
        tick;

        // rd0 and we0 together: write wins.
        addr0 = 32'h20; wdata0 = 32'hDEAD_BEEF; rd0 = 1; we0 = 1;
        tick;
        check("rw_we", {31'd0, mem_we}, 32'd1);
        check("rw_rd", {31'd0, mem_rd}, 32'd0);
        check("rw_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("rw_addr", mem_addr, 32'h20);
        tick;
        check("rw_v0", {31'd0, valid0}, 32'd1);
        check("rw_d0", data0, 32'hC0DE_0002);
        rd0 = 0; we0 = 0;
        tick;

        // Reset lands in the middle of a read.
        addr1 = 32'h30; rd1 = 1; mem_data = 32'h9999_9999;
        tick;
        tick;
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1; rd1 = 0;
        tick;
        check("mr_addr", mem_addr, 32'd0);
        check("mr_wdata", mem_wdata, 32'd0);
        check("mr_d0", data0, 32'd0);
        check("mr_d1", data1, 32'd0);
        check("mr_busy", {31'd0, busy}, 32'd0);
        check("mr_v1", {31'd0, valid1}, 32'd0);
        tick;
        check("mr_v1b", {31'd0, valid1}, 32'd0);
        check("mr_rd", {31'd0, mem_rd}, 32'd0);
        rst = 0;
        tick;
        check("mr_v1c", {31'd0, valid1}, 32'd0);

        // Fresh read after reset.
        addr1 = 32'h40; rd1 = 1; mem_data = 32'h7777_7777;
        tick;
        check("fr_strobe", {31'd0, mem_rd}, 32'd1);
        check("fr_addr", mem_addr, 32'h40);
        tick;
        tick;
        tick;
        check("fr_v1", {31'd0, valid1}, 32'd1);
        check("fr_d1", data1, 32'h7777_7777);
        rd1 = 0;
        tick;
        check("fr_idle", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
